// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the frame-buffer SRAM arbiter.
// Optional write-starvation guard is enabled with SRAM_ARB_STARVE_EN.
package sram_arb_pkg;

    localparam int ADDR_W_DEF     = 20;
    localparam int DATA_W_DEF     = 16;
    localparam int RD_LAT_DEF     = 3;
    localparam int WR_CYC_DEF     = 2;
    localparam int STARVE_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        WHOLD = 2'd3
    } arb_state_e;

    // Width of a down-counter that must hold max(rd_lat, wr_cyc) - 1.
    function automatic int cnt_width(input int rd_lat, input int wr_cyc);
        int m;
        m = (rd_lat > wr_cyc) ? rd_lat : wr_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int CNT_W = cnt_width(RD_LAT_DEF, WR_CYC_DEF);

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for the SRAM arbiter.
// master = display/rasterizer side, slave = arbiter side.
interface sram_arbiter_if #(
    parameter int ADDR_W = sram_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = sram_arb_pkg::DATA_W_DEF
);

    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_ack;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;

    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ack;

    modport master (
        output i_rd_req, i_rd_addr,
        output i_wr_req, i_wr_addr, i_wr_data,
        input  o_rd_ack, o_rd_valid, o_rd_data,
        input  o_wr_ack
    );

    modport slave (
        input  i_rd_req, i_rd_addr,
        input  i_wr_req, i_wr_addr, i_wr_data,
        output o_rd_ack, o_rd_valid, o_rd_data,
        output o_wr_ack
    );

endinterface

// File: rtl/sram_arb_starve.sv
// Saturating count of cycles a write has waited without an ack.
// Only instantiated when SRAM_ARB_STARVE_EN is defined.
module sram_arb_starve
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_clr,
    output logic o_force
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_cnt;

    // Count pending-write cycles, saturate, clear when the write is acked.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_req && (r_cnt != SW'(STARVE_MAX))) begin
            r_cnt <= r_cnt + SW'(1);
        end
    end

    assign o_force = (r_cnt == SW'(STARVE_MAX));

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the external frame-buffer SRAM (display read, raster write).
// Define SRAM_ARB_STARVE_EN to let a long-waiting write pre-empt reads.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int WR_CYC = WR_CYC_DEF
`ifdef SRAM_ARB_STARVE_EN
   ,parameter int STARVE_MAX = STARVE_MAX_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    sram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [DATA_W-1:0] io_sram_data,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_busy
);

    localparam int CW = cnt_width(RD_LAT, WR_CYC);

    arb_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_drv;
    logic              r_we_n;
    logic              r_oe_n;
    logic              r_busy;
    logic              r_rd_ack;
    logic              r_wr_ack;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_grant_rd;
    logic              w_grant_wr;

`ifdef SRAM_ARB_STARVE_EN
    logic              w_force;

    sram_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .i_req   (bus.i_wr_req),
        .i_clr   (r_wr_ack),
        .o_force (w_force)
    );

    assign w_grant_wr = bus.i_wr_req & (~bus.i_rd_req | w_force);
`else
    assign w_grant_wr = bus.i_wr_req & ~bus.i_rd_req;
`endif

    assign w_grant_rd = bus.i_rd_req & ~w_grant_wr;

    // Access sequencer: arbitrate in IDLE, time oe/we, always return via IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_drv      <= 1'b0;
            r_we_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_ack   <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_wr) begin
                        r_state  <= WRITE;
                        r_addr   <= bus.i_wr_addr;
                        r_wdata  <= bus.i_wr_data;
                        r_drv    <= 1'b1;
                        r_we_n   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_wr_ack <= 1'b1;
                        r_cnt    <= CW'(WR_CYC - 1);
                    end else if (w_grant_rd) begin
                        r_state  <= READ;
                        r_addr   <= bus.i_rd_addr;
                        r_oe_n   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_rd_ack <= 1'b1;
                        r_cnt    <= CW'(RD_LAT - 1);
                    end
                end
                READ: begin
                    if (r_cnt == '0) begin
                        r_state    <= IDLE;
                        r_oe_n     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_rd_data  <= io_sram_data;
                        r_rd_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                WRITE: begin
                    if (r_cnt == '0) begin
                        r_state <= WHOLD;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                WHOLD: begin
                    r_state <= IDLE;
                    r_drv   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_sram_data   = r_drv ? r_wdata : {DATA_W{1'bz}};
    assign o_sram_addr    = r_addr;
    assign o_sram_we_n    = r_we_n;
    assign o_sram_oe_n    = r_oe_n;
    assign o_busy         = r_busy;

    assign bus.o_rd_ack   = r_rd_ack;
    assign bus.o_wr_ack   = r_wr_ack;
    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM.
// Starvation expectations follow SRAM_ARB_STARVE_EN.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    wire  [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n;
    logic        oe_n;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int viol   = 0;

    always #5 clk = ~clk;

    sram_arbiter_if u_if ();

    sram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (u_if),
        .o_sram_addr  (sram_addr),
        .io_sram_data (sram_dq),
        .o_sram_we_n  (we_n),
        .o_sram_oe_n  (oe_n),
        .o_busy       (busy)
    );

    // SRAM model: stores while we_n low; drives read data after oe_n low 2 cycles
    logic [15:0] mem [bit [19:0]];
    logic [1:0]  m_cnt = 2'd0;
    logic [15:0] m_q   = 16'h0;

    always @(posedge clk) begin
        if (!we_n) mem[sram_addr] = sram_dq;
        if (oe_n) m_cnt <= 2'd0;
        else if (m_cnt != 2'd3) m_cnt <= m_cnt + 2'd1;
        m_q <= mem.exists(sram_addr) ? mem[sram_addr] : 16'h0;
    end

    assign sram_dq = (!oe_n && m_cnt >= 2'd2) ? m_q : 16'hzzzz;

    // Turnaround monitor: oe_n and data driver never together or adjacent
    logic p_oe  = 1'b0;
    logic p_drv = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if ((!oe_n && dut.r_drv) || (p_oe && dut.r_drv) ||
                (p_drv && !oe_n)) viol++;
        end
        p_oe  = !oe_n;
        p_drv = dut.r_drv;
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (oe_n !== 1'b1 || we_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_strobes: oe_n=%b we_n=%b want 1 1", oe_n, we_n);
        end
        n_chk++;
        if (busy !== 1'b0 || sram_addr !== 20'h0) begin
            n_fail++;
            $display("FAIL rst_busy_addr: busy=%b addr=%h want 0 0", busy, sram_addr);
        end
        n_chk++;
        if (u_if.o_rd_data !== 16'h0 || dut.r_drv !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_data: rd_data=%h drv=%b want 0 0",
                     u_if.o_rd_data, dut.r_drv);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: busy=%b want 0", busy);
        end
        u_if.i_rd_addr = 20'h0012C;
        u_if.i_rd_req  = 1'b1;
        @(negedge clk);
        n_chk++;
        if (u_if.o_rd_ack !== 1'b1 || oe_n !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pre: ack=%b oe_n=%b want 1 0", u_if.o_rd_ack, oe_n);
        end
        u_if.i_rd_req = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (oe_n !== 1'b1 || we_n !== 1'b1 || dut.r_drv !== 1'b0 ||
                u_if.o_rd_ack !== 1'b0 || u_if.o_rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_hold: oe_n=%b we_n=%b drv=%b ack=%b vld=%b want 1 1 0 0 0",
                         oe_n, we_n, dut.r_drv, u_if.o_rd_ack, u_if.o_rd_valid);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || u_if.o_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_release: busy=%b vld=%b want 0 0", busy, u_if.o_rd_valid);
        end
    endtask

    task automatic test_single_read();
        int oe_low = 0;
        int acks   = 0;
        int vcyc   = -1;
        logic [15:0] d = 16'h0;
        u_if.i_rd_addr = 20'h0012C;
        u_if.i_rd_req  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (!oe_n) oe_low++;
            if (u_if.o_rd_ack) begin
                acks++;
                u_if.i_rd_req = 1'b0;
            end
            if (u_if.o_rd_valid) begin
                vcyc = c;
                d    = u_if.o_rd_data;
            end
        end
        n_chk++;
        if (oe_low !== 3) begin
            n_fail++;
            $display("FAIL rd_oe_cycles: got %0d want 3", oe_low);
        end
        n_chk++;
        if (acks !== 1) begin
            n_fail++;
            $display("FAIL rd_ack_count: got %0d want 1", acks);
        end
        n_chk++;
        if (vcyc !== 4) begin
            n_fail++;
            $display("FAIL rd_valid_cycle: got %0d want 4", vcyc);
        end
        n_chk++;
        if (d !== 16'hA5C3 || u_if.o_rd_data !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL rd_data: got %h held %h want a5c3", d, u_if.o_rd_data);
        end
    endtask

    task automatic test_single_write();
        int we_low = 0;
        int acks   = 0;
        u_if.i_wr_addr = 20'h4B000;
        u_if.i_wr_data = 16'h2B2B;
        u_if.i_wr_req  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (!we_n) we_low++;
            if (u_if.o_wr_ack) begin
                acks++;
                u_if.i_wr_req = 1'b0;
            end
            if (c == 3) begin
                n_chk++;
                if (we_n !== 1'b1 || busy !== 1'b1 || sram_dq !== 16'h2B2B ||
                    sram_addr !== 20'h4B000) begin
                    n_fail++;
                    $display("FAIL wr_hold: we_n=%b busy=%b dq=%h addr=%h want 1 1 2b2b 4b000",
                             we_n, busy, sram_dq, sram_addr);
                end
            end
            if (c == 4) begin
                n_chk++;
                if (busy !== 1'b0 || dut.r_drv !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_release: busy=%b drv=%b want 0 0", busy, dut.r_drv);
                end
            end
        end
        n_chk++;
        if (we_low !== 2) begin
            n_fail++;
            $display("FAIL wr_we_cycles: got %0d want 2", we_low);
        end
        n_chk++;
        if (acks !== 1) begin
            n_fail++;
            $display("FAIL wr_ack_count: got %0d want 1", acks);
        end
        n_chk++;
        if (!mem.exists(20'h4B000) || mem[20'h4B000] !== 16'h2B2B) begin
            n_fail++;
            $display("FAIL wr_mem: got %h want 2b2b",
                     mem.exists(20'h4B000) ? mem[20'h4B000] : 16'hxxxx);
        end
    endtask

    task automatic test_simultaneous();
        int rack = -1;
        int wack = -1;
        u_if.i_rd_addr = 20'h0012C;
        u_if.i_wr_addr = 20'h00040;
        u_if.i_wr_data = 16'h5A5A;
        u_if.i_rd_req  = 1'b1;
        u_if.i_wr_req  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (u_if.o_rd_ack && rack < 0) begin
                rack = c;
                u_if.i_rd_req = 1'b0;
            end
            if (u_if.o_wr_ack && wack < 0) begin
                wack = c;
                u_if.i_wr_req = 1'b0;
            end
        end
        n_chk++;
        if (rack !== 1) begin
            n_fail++;
            $display("FAIL sim_rd_first: rd ack cycle %0d want 1", rack);
        end
        n_chk++;
        if (wack !== 5) begin
            n_fail++;
            $display("FAIL sim_wr_after: wr ack cycle %0d want 5", wack);
        end
        n_chk++;
        if (!mem.exists(20'h00040) || mem[20'h00040] !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL sim_wr_mem: got %h want 5a5a",
                     mem.exists(20'h00040) ? mem[20'h00040] : 16'hxxxx);
        end
        n_chk++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL sim_turnaround: %0d violations want 0", viol);
        end
    endtask

    task automatic test_starve();
        int wack    = -1;
        int rafter  = -1;
        int nbefore = 0;
        u_if.i_rd_addr = 20'h0012C;
        u_if.i_wr_addr = 20'h00080;
        u_if.i_wr_data = 16'hBEEF;
        u_if.i_rd_req  = 1'b1;
        u_if.i_wr_req  = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (u_if.o_wr_ack) begin
                if (wack < 0) wack = c;
                u_if.i_wr_req = 1'b0;
            end
            if (u_if.o_rd_ack) begin
                if (wack < 0) nbefore++;
                else if (rafter < 0) rafter = c;
            end
            if (rafter > 0) break;
        end
        u_if.i_rd_req = 1'b0;
        u_if.i_wr_req = 1'b0;
        repeat (6) @(negedge clk);
`ifdef SRAM_ARB_STARVE_EN
        n_chk++;
        if (wack !== 9) begin
            n_fail++;
            $display("FAIL starve_wr_ack: cycle %0d want 9", wack);
        end
        n_chk++;
        if (nbefore !== 2 || rafter !== 13) begin
            n_fail++;
            $display("FAIL starve_reads: before=%0d after_cycle=%0d want 2 13",
                     nbefore, rafter);
        end
        n_chk++;
        if (!mem.exists(20'h00080) || mem[20'h00080] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL starve_mem: got %h want beef",
                     mem.exists(20'h00080) ? mem[20'h00080] : 16'hxxxx);
        end
`else
        n_chk++;
        if (wack !== -1) begin
            n_fail++;
            $display("FAIL starve_no_wr: wr ack at cycle %0d want none", wack);
        end
        n_chk++;
        if (nbefore < 40) begin
            n_fail++;
            $display("FAIL starve_reads: %0d read acks want >= 40", nbefore);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int  cyc  = 0;
        int  last = 0;
        bit  ok;
        for (int i = 0; i < 4; i++) begin
            u_if.i_wr_addr = 20'(i);
            u_if.i_wr_data = 16'hC000 | 16'(i);
            u_if.i_wr_req  = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 10 && !ok; t++) begin
                @(negedge clk);
                cyc++;
                if (u_if.o_wr_ack) ok = 1'b1;
            end
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b2b_wack%0d: no ack in 10 cycles want ack", i);
            end
            if (i > 0) begin
                n_chk++;
                if (cyc - last !== 4) begin
                    n_fail++;
                    $display("FAIL b2b_gap%0d: got %0d want 4", i, cyc - last);
                end
            end
            last = cyc;
        end
        u_if.i_wr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || we_n !== 1'b1 || dut.r_drv !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_whold: busy=%b we_n=%b drv=%b want 1 1 1",
                     busy, we_n, dut.r_drv);
        end
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_wr_idle: busy=%b want 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            u_if.i_rd_addr = 20'(i);
            u_if.i_rd_req  = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 10 && !ok; t++) begin
                @(negedge clk);
                if (u_if.o_rd_ack) ok = 1'b1;
            end
            u_if.i_rd_req = 1'b0;
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b2b_rack%0d: no ack in 10 cycles want ack", i);
            end
            ok = 1'b0;
            for (int t = 0; t < 10 && !ok; t++) begin
                @(negedge clk);
                if (u_if.o_rd_valid) ok = 1'b1;
            end
            n_chk++;
            if (!ok || u_if.o_rd_data !== (16'hC000 | 16'(i)) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_rdata%0d: vld=%b data=%h busy=%b want 1 %h 0",
                         i, ok, u_if.o_rd_data, busy, 16'hC000 | 16'(i));
            end
        end
    endtask

    initial begin
        u_if.i_rd_req  = 1'b0;
        u_if.i_rd_addr = 20'h0;
        u_if.i_wr_req  = 1'b0;
        u_if.i_wr_addr = 20'h0;
        u_if.i_wr_data = 16'h0;
        mem[20'h0012C] = 16'hA5C3;
        test_reset();
        repeat (2) @(negedge clk);
        test_single_read();
        repeat (2) @(negedge clk);
        test_single_write();
        repeat (2) @(negedge clk);
        test_simultaneous();
        repeat (2) @(negedge clk);
        test_starve();
        repeat (2) @(negedge clk);
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_chk++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL turnaround_total: %0d violations want 0", viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external frame-buffer SRAM (20-bit word address, 16-bit data, active-low we/oe) between two requesters.
  - Requester 1 is the scan-out read port (display).
  - Requester 2 is the rasterizer write port (pseudo_proc pixel stores).
- Sequences each access with fixed read-latency and write-pulse timing.
- Guarantees a bus turnaround cycle between accesses.
- Sits between pseudo_proc/display logic and the SRAM pins.

Parameters:
- ADDR_W, 20, SRAM word address width (o_sram_addr[20:1]).
- DATA_W, 16, SRAM data width.
- RD_LAT, 3, cycles oe_n is held low; data sampled on the last of these edges.
- WR_CYC, 2, cycles we_n is held low.
- STARVE_MAX, 8, pending-write cycles before the write is forced ahead of reads (only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- i_rd_req  in  1  read request; held until o_rd_ack.
- i_rd_addr  in  ADDR_W  read address; stable while i_rd_req is high.
- o_rd_ack  out  1  one-cycle pulse: read accepted.
- o_rd_valid  out  1  one-cycle pulse: o_rd_data is valid.
- o_rd_data  out  DATA_W  read data, held until the next read completes.
- i_wr_req  in  1  write request; held until o_wr_ack.
- i_wr_addr  in  ADDR_W  write address.
- i_wr_data  in  DATA_W  write data.
- o_wr_ack  out  1  one-cycle pulse: write accepted (address and data latched).
- o_sram_addr  out  ADDR_W  SRAM address.
- io_sram_data  inout  DATA_W  SRAM data bus; driven only in WRITE and WHOLD.
- o_sram_we_n  out  1  SRAM write enable, active low.
- o_sram_oe_n  out  1  SRAM output enable, active low.
- o_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to IDLE.
  - o_sram_we_n = 1, o_sram_oe_n = 1, io_sram_data = Z, o_sram_addr = 0.
  - o_rd_ack, o_wr_ack, o_rd_valid, o_busy = 0; o_rd_data = 0; starvation counter = 0.
  - Reset mid-access aborts the access with no ack or valid. A write already strobed is not rolled back.
- States: IDLE, READ, WRITE, WHOLD.
- IDLE:
  - Bus released, both strobes high.
  - On an edge with any request, latch the winner's address (and data for a write) and move to READ or WRITE.
  - The matching ack is a registered pulse in the first cycle of the new state.
- Arbitration:
  - Read wins when both requests are high (display priority), unless the starvation condition holds (see Optional Feature).
  - A request already acked is not re-granted, even if the requester leaves its req high for that ack cycle.
- READ:
  - o_sram_oe_n = 0 and o_sram_addr = latched address for RD_LAT cycles.
  - io_sram_data is sampled into o_rd_data on the final edge; the state then returns to IDLE.
  - o_rd_valid pulses in the first IDLE cycle.
  - Latency: request sampled at edge k → oe_n low during cycles k+1..k+RD_LAT → o_rd_valid high in cycle k+RD_LAT+1.
- WRITE:
  - Data driven and o_sram_we_n = 0 for WR_CYC cycles, then WHOLD.
- WHOLD:
  - One cycle with we_n = 1 and data/address still driven (hold time), then IDLE.
- Turnaround: the mandatory IDLE cycle between any two accesses ensures oe_n and the data driver are never active together or back-to-back.
- Occupancy: a read occupies RD_LAT+1 cycles; a write occupies WR_CYC+2 cycles.
- Requests that drop before ack are ignored; no internal queueing.

Optional Feature:
- Macro: SRAM_ARB_STARVE_EN.
- Defined:
  - A counter increments each cycle i_wr_req is high and not acked (saturating at STARVE_MAX); it clears on o_wr_ack.
  - When count == STARVE_MAX, the write wins the next IDLE arbitration even if i_rd_req is high.
- Undefined: strict read priority; writes can starve indefinitely; no counter logic.

Decomposition:
- Package sram_arb_pkg:
  - State enum (IDLE, READ, WRITE, WHOLD).
  - ADDR_W and DATA_W defaults.
  - A localparam for the state-counter width, derived from max(RD_LAT, WR_CYC).
- Sub-module: sram_arb_starve (saturating starvation counter with clear and a "force" output), instantiated only under SRAM_ARB_STARVE_EN.

Test Plan:
- Reset: hold rst low 3 cycles during an active READ → we_n = oe_n = 1, data Z, no ack or valid; release → IDLE, o_busy = 0.
- Single read: i_rd_addr = 20'h0012C, SRAM model returns 16'hA5C3 after 2-cycle delay → oe_n low exactly 3 cycles, o_rd_valid in cycle k+4 with o_rd_data = 16'hA5C3.
- Single write: i_wr_addr = 20'h4B000, i_wr_data = 16'h2B2B → we_n low 2 cycles, data held one extra cycle, model location 20'h4B000 = 16'h2B2B, o_wr_ack one pulse.
- Simultaneous requests: i_rd_req and i_wr_req rise on the same edge → read acked first; write acked in the cycle after the post-read IDLE; at least one IDLE cycle between oe_n and the data driver.
- Starvation (macro defined): i_rd_req held high continuously, write pending → write acked once the counter reaches 8, then reads resume. Macro undefined → no write ack for 200 cycles.
- Back-to-back: 4 raster writes to 20'h00000..20'h00003, then readback → data match; o_busy drops only after the final WHOLD or read.
